// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO between the CPU MEM stage and data memory.
// Stores are queued as {word address, byte lanes, data} and drained head-first.
// Loads are stalled while any queued store targets the same 32-bit word.
// Store data is never forwarded to loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_byteEn,
    input  logic [31:0] st_wdata,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        mem_wvalid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteEn,
    output logic [31:0] mem_wdata,
    input  logic        mem_wready,
    output logic [3:0]  count
);

    localparam int PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [PW-1:0] headPtr_q, headPtr_d;
    logic [PW-1:0] tailPtr_q, tailPtr_d;
    logic [3:0]    count_q, count_d;
    logic [DEPTH-1:0] entryValid_q;
    logic [29:0]   entryAddr_q   [DEPTH];
    logic [3:0]    entryByteEn_q [DEPTH];
    logic [31:0]   entryData_q   [DEPTH];

    logic pushEn;
    logic popEn;
    logic notEmpty;
    logic unusedAddrBits;

    assign unusedAddrBits = ^{st_addr[1:0], ld_addr[1:0]};

    assign notEmpty   = (count_q != 4'd0);
    assign st_ready   = (count_q != DEPTH_C);
    assign mem_wvalid = notEmpty;
    assign count      = count_q;

    assign pushEn = st_valid && st_ready && (st_byteEn != 4'b0000);
    assign popEn  = notEmpty && mem_wready;

    assign mem_addr   = notEmpty ? {entryAddr_q[headPtr_q], 2'b00} : 32'd0;
    assign mem_byteEn = notEmpty ? entryByteEn_q[headPtr_q] : 4'd0;
    assign mem_wdata  = notEmpty ? entryData_q[headPtr_q] : 32'd0;

    // Next pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (popEn) begin
            headPtr_d = headPtr_q + PW'(1);
        end
        if (pushEn) begin
            tailPtr_d = tailPtr_q + PW'(1);
        end
        if (pushEn && !popEn) begin
            count_d = count_q + 4'd1;
        end else if (popEn && !pushEn) begin
            count_d = count_q - 4'd1;
        end
    end

    // Word-granular hazard check against every occupied entry, including a head being popped.
    always_comb begin
        ld_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_valid && entryValid_q[i] && (entryAddr_q[i] == ld_addr[31:2])) begin
                ld_stall = 1'b1;
            end
        end
    end

    // Queue state; reset clears everything at once and drops any pending stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr_q    <= '0;
            tailPtr_q    <= '0;
            count_q      <= 4'd0;
            entryValid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryAddr_q[i]   <= '0;
                entryByteEn_q[i] <= '0;
                entryData_q[i]   <= '0;
            end
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            if (popEn) begin
                entryValid_q[headPtr_q] <= 1'b0;
            end
            if (pushEn) begin
                entryValid_q[tailPtr_q]  <= 1'b1;
                entryAddr_q[tailPtr_q]   <= st_addr[31:2];
                entryByteEn_q[tailPtr_q] <= st_byteEn;
                entryData_q[tailPtr_q]   <= st_wdata;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vectors for store_buffer (DEPTH = 4) with
// hand-computed expected values.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_byteEn;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        mem_wvalid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteEn;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic [3:0]  count;

    int testsRun;
    int testsFailed;

    store_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_byteEn  (st_byteEn),
        .st_wdata   (st_wdata),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_stall   (ld_stall),
        .mem_wvalid (mem_wvalid),
        .mem_addr   (mem_addr),
        .mem_byteEn (mem_byteEn),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .count      (count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [3:0] sbe,
                                 input logic [31:0] sd, input logic lv, input logic [31:0] la,
                                 input logic wr);
        st_valid   = sv;
        st_addr    = sa;
        st_byteEn  = sbe;
        st_wdata   = sd;
        ld_valid   = lv;
        ld_addr    = la;
        mem_wready = wr;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wr);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0, wr);
    endtask

    // Push one full-word store with memory held off.
    task automatic pushHeld(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, 4'hF, d, 1'b0, 32'd0, 1'b0);
        cycle();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0);

        // Reset state, before any clock edge
        #1;
        checkOutput("rst_st_ready", 32'(st_ready), 32'd1);
        checkOutput("rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_ld_stall", 32'(ld_stall), 32'd0);
        #10;
        reset = 1'b0;
        cycle();

        // Single store: no pass-through, visible one cycle later, drained one after
        applyStimulus(1'b1, 32'h0000_1006, 4'b1100, 32'hABCD_0000, 1'b0, 32'd0, 1'b1);
        checkOutput("single_no_passthru", 32'(mem_wvalid), 32'd0);
        checkOutput("single_st_ready", 32'(st_ready), 32'd1);
        cycle();
        idle(1'b1);
        checkOutput("single_wvalid", 32'(mem_wvalid), 32'd1);
        checkOutput("single_addr", mem_addr, 32'h0000_1004);
        checkOutput("single_be", 32'(mem_byteEn), 32'hC);
        checkOutput("single_data", mem_wdata, 32'hABCD_0000);
        checkOutput("single_count1", 32'(count), 32'd1);
        cycle();
        checkOutput("single_count0", 32'(count), 32'd0);
        checkOutput("single_wvalid0", 32'(mem_wvalid), 32'd0);
        checkOutput("single_addr0", mem_addr, 32'd0);

        // Fill and backpressure: fifth store refused
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h10 + 32'(4 * i), 4'hF, 32'hD0 + 32'(i), 1'b0, 32'd0, 1'b0);
            checkOutput("fill_st_ready", 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
            cycle();
        end
        idle(1'b0);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_head_held", mem_addr, 32'h10);
        cycle();
        checkOutput("fill_head_stable", mem_addr, 32'h10);
        // Full with a store offered: pop only
        applyStimulus(1'b1, 32'h24, 4'hF, 32'hEE, 1'b0, 32'd0, 1'b1);
        checkOutput("full_st_ready", 32'(st_ready), 32'd0);
        checkOutput("drain_addr0", mem_addr, 32'h10);
        checkOutput("drain_data0", mem_wdata, 32'hD0);
        cycle();
        idle(1'b1);
        checkOutput("full_pop_count", 32'(count), 32'd3);
        checkOutput("full_ready_rises", 32'(st_ready), 32'd1);
        for (int j = 1; j < 4; j++) begin
            checkOutput("drain_addr", mem_addr, 32'h10 + 32'(4 * j));
            checkOutput("drain_data", mem_wdata, 32'hD0 + 32'(j));
            cycle();
        end
        checkOutput("drain_empty", 32'(count), 32'd0);

        // Load hazard against a pending store
        pushHeld(32'h0000_2000, 32'h1111_1111);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h0000_2003, 1'b0);
        checkOutput("hz_same_word", 32'(ld_stall), 32'd1);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h0000_2004, 1'b0);
        checkOutput("hz_next_word", 32'(ld_stall), 32'd0);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'h0000_2000, 1'b0);
        checkOutput("hz_no_load", 32'(ld_stall), 32'd0);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h0000_2000, 1'b1);
        checkOutput("hz_popping_head", 32'(ld_stall), 32'd1);
        cycle();
        checkOutput("hz_after_pop", 32'(ld_stall), 32'd0);
        checkOutput("hz_count0", 32'(count), 32'd0);
        // Store being pushed this cycle is not yet visible to the hazard check
        applyStimulus(1'b1, 32'h0000_3000, 4'hF, 32'h2222_2222, 1'b1, 32'h0000_3000, 1'b0);
        checkOutput("hz_push_excluded", 32'(ld_stall), 32'd0);
        cycle();
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'h0000_3000, 1'b0);
        checkOutput("hz_pushed_visible", 32'(ld_stall), 32'd1);
        idle(1'b1);
        cycle();
        checkOutput("hz_drained", 32'(count), 32'd0);

        // Null store is discarded
        applyStimulus(1'b1, 32'h40, 4'b0000, 32'h5555_5555, 1'b0, 32'd0, 1'b1);
        checkOutput("null_st_ready", 32'(st_ready), 32'd1);
        cycle();
        idle(1'b1);
        checkOutput("null_count", 32'(count), 32'd0);
        checkOutput("null_wvalid", 32'(mem_wvalid), 32'd0);

        // Simultaneous push/pop at count 2 with tail wrapping
        pushHeld(32'h100, 32'hA);
        pushHeld(32'h104, 32'hB);
        idle(1'b1);
        checkOutput("wrap_pre_a", mem_addr, 32'h100);
        cycle();
        checkOutput("wrap_pre_b", mem_addr, 32'h104);
        cycle();
        pushHeld(32'h200, 32'hC);
        pushHeld(32'h204, 32'hD);
        applyStimulus(1'b1, 32'h208, 4'hF, 32'hE, 1'b0, 32'd0, 1'b1);
        checkOutput("pp_head_c", mem_wdata, 32'hC);
        cycle();
        checkOutput("pp_count_a", 32'(count), 32'd2);
        applyStimulus(1'b1, 32'h20C, 4'hF, 32'hF, 1'b0, 32'd0, 1'b1);
        checkOutput("pp_head_d", mem_wdata, 32'hD);
        cycle();
        checkOutput("pp_count_b", 32'(count), 32'd2);
        idle(1'b1);
        checkOutput("pp_head_e", mem_addr, 32'h208);
        cycle();
        checkOutput("pp_head_f", mem_addr, 32'h20C);
        cycle();
        checkOutput("pp_empty", 32'(count), 32'd0);

        // Asynchronous reset between edges with three stores pending
        pushHeld(32'h300, 32'h30);
        pushHeld(32'h304, 32'h31);
        pushHeld(32'h308, 32'h32);
        idle(1'b0);
        checkOutput("ar_count3", 32'(count), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("ar_wvalid", 32'(mem_wvalid), 32'd0);
        checkOutput("ar_count", 32'(count), 32'd0);
        checkOutput("ar_st_ready", 32'(st_ready), 32'd1);
        checkOutput("ar_mem_data", mem_wdata, 32'd0);
        reset = 1'b0;
        #1;
        cycle();
        checkOutput("ar_no_stale", 32'(mem_wvalid), 32'd0);
        applyStimulus(1'b1, 32'h400, 4'h3, 32'h4444, 1'b0, 32'd0, 1'b0);
        cycle();
        idle(1'b1);
        checkOutput("ar_push_count", 32'(count), 32'd1);
        checkOutput("ar_push_addr", mem_addr, 32'h400);
        checkOutput("ar_push_be", 32'(mem_byteEn), 32'h3);
        cycle();
        checkOutput("ar_final_empty", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered store entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port st_valid  input  1  the CPU MEM stage presents a store this cycle.
REQ-005 SHALL have port st_addr  input  32  store byte address; only bits 31:2 are stored.
REQ-006 SHALL have port st_byteEn  input  4  byte lanes already produced by the byte-enable stage.
REQ-007 SHALL have port st_wdata  input  32  lane-shifted store data.
REQ-008 SHALL have port st_ready  output  1  the buffer accepts the store this cycle.
REQ-009 SHALL have port ld_valid  input  1  the CPU MEM stage presents a load this cycle.
REQ-010 SHALL have port ld_addr  input  32  load byte address.
REQ-011 SHALL have port ld_stall  output  1  the load must hold because a pending store targets the same word.
REQ-012 SHALL have port mem_wvalid  output  1  the head entry is presented to memory.
REQ-013 SHALL have port mem_addr  output  32  head word address, with bits 1:0 equal to 00.
REQ-014 SHALL have port mem_byteEn  output  4  head byte lanes.
REQ-015 SHALL have port mem_wdata  output  32  head data.
REQ-016 SHALL have port mem_wready  input  1  memory accepts the head entry this cycle.
REQ-017 SHALL have port count  output  4  number of occupied entries, 0..DEPTH.

Function
REQ-018 SHALL operate as an in-order FIFO of {addr[31:2], byteEn, wdata} entries with head and tail pointers that wrap modulo DEPTH.
REQ-019 SHALL drive st_ready = (count != DEPTH); the full condition is evaluated on registered state, with no same-cycle bypass of a pop.
REQ-020 SHALL push the store at the tail and advance the tail when st_valid && st_ready && st_byteEn != 4'b0000.
REQ-021 SHALL treat st_valid with st_byteEn == 4'b0000 as accepted and discarded: it makes no push, makes no count change, and still drives st_ready as in REQ-019.
REQ-022 SHALL drive mem_wvalid = (count != 0), with mem_addr, mem_byteEn and mem_wdata taken combinationally from the head entry.
REQ-023 SHALL drive mem_addr, mem_byteEn and mem_wdata to 0 when the buffer is empty.
REQ-024 SHALL pop the head and advance the head when mem_wvalid && mem_wready.
REQ-025 SHALL keep the head outputs stable while mem_wvalid=1 and mem_wready=0.
REQ-026 SHALL update count by +1 on a push only, by -1 on a pop only, and leave it unchanged on a simultaneous push and pop.
REQ-027 SHALL permit a simultaneous push and pop at every count from 1 to DEPTH-1.
REQ-028 SHALL, at count=0, permit a push with no pop; mem_wvalid rises in the next cycle, so there is no combinational pass-through.
REQ-029 SHALL, at count=DEPTH, perform a pop only; st_ready rises in the next cycle.
REQ-030 SHALL drive ld_stall = ld_valid && (some occupied entry has addr[31:2] == ld_addr[31:2]); the byte-lane overlap is ignored.
REQ-031 SHALL include the head entry being popped this cycle in the ld_stall comparison.
REQ-032 SHALL exclude a store being pushed this cycle from the ld_stall comparison.
REQ-033 SHALL NOT forward store data to loads.
REQ-034 SHALL drain entries strictly in push order, so two stores to one word reach memory in program order.

Reset
REQ-035 SHALL, while reset=1, immediately clear head, tail and count to 0 and invalidate all entries.
REQ-036 SHALL hold st_ready=1, mem_wvalid=0, ld_stall=0 and mem_addr/mem_byteEn/mem_wdata=0 from the assertion of reset onward, regardless of clk.
REQ-037 SHALL discard any in-flight pending stores when reset asserts mid-operation; this discard is intentional.
REQ-038 SHALL need no clock edge to reach the reset state, and SHALL accept a push on the first rising clk edge after reset deasserts.

Verification
REQ-039 Scenario "single store": store addr 0x0000_1006, byteEn 1100, wdata 0xABCD_0000, mem_wready=1 -> next cycle mem_wvalid=1, mem_addr=0x0000_1004, mem_byteEn=1100, mem_wdata=0xABCD_0000; count returns 0 one cycle later.
REQ-040 Scenario "fill and backpressure": mem_wready=0, five stores to 0x10, 0x14, 0x18, 0x1C, 0x20 -> count=4 and st_ready=0 after the fourth; the fifth is not accepted; mem_wready=1 then drains 0x10, 0x14, 0x18, 0x1C in order.
REQ-041 Scenario "load hazard": store word 0x0000_2000 pending with mem_wready=0, load at ld_addr 0x0000_2003 -> ld_stall=1; load at 0x0000_2004 -> ld_stall=0; one cycle after mem_wready=1 pops the entry, ld_stall=0.
REQ-042 Scenario "null store": st_valid with byteEn 0000 -> count unchanged and mem_wvalid stays 0.
REQ-043 Scenario "simultaneous push/pop at count=2 with wrap": tail at index 3 -> count stays 2, tail wraps to 0, drain order is preserved.
REQ-044 Scenario "async reset mid-drain": count=3, reset pulse between clock edges -> mem_wvalid=0 and count=0 before the next edge; no stale entry appears after release.
